mem_arbiter: RTL and testbench

Multi-cycle arbiter sharing the single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 8-bit CPU. It accepts one transaction at a time from either requester over a req/ack handshake, sequences it onto the fixed-latency memory port, and returns read data with a one-cycle ack. It also enforces halt (no new instruction fetches) and counts fetch/data conflicts for performance tuning.

---
 rtl/mem_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port unified memory of the 8-bit CPU between the fetch
// stage (instruction reads) and the memory stage (data loads/stores). One
// transaction is accepted at a time over a req/ack handshake. The transaction
// is placed on the fixed-latency memory port, and the read data comes back
// with a one-cycle ack. While hlt is high, no new fetch is granted. Cycles in
// which both requesters compete are counted for performance tuning.
//
// Transaction timeline (cycle 0 = IDLE cycle in which the request is sampled):
//   cycle 1               ISSUE : mem_en pulse, address/we/wdata on memory port
//   cycles 2..MEM_LAT+1   WAIT  : latency countdown, read data captured last
//   cycle MEM_LAT+2       ACK   : owner's ack pulse with registered rdata
//
// Parameters:
//   AW       address width
//   DW       data width
//   MEM_LAT  memory read latency after the mem_en sampling edge (1..7)
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined     -> on a conflict, the grant goes to the
//                                      port not granted most recently (the
//                                      first conflict after reset goes to data)
//                       not defined -> fixed data-over-fetch priority
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   hlt               CPU halted: new fetch grants are blocked
//   if_req/if_addr    fetch request (held until if_ack) and address
//   if_ack/if_rdata   fetch completion pulse and instruction byte
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_ack/d_rdata     data completion pulse and load data (0 for stores)
//   mem_en/mem_we/mem_addr/mem_wdata  memory port command
//   mem_rdata         memory read data, valid MEM_LAT cycles after mem_en
//   busy              high whenever the arbiter is not IDLE
//   conflict_cnt      saturating count of IDLE cycles with both requests eligible
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hlt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [7:0]    conflict_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  // Countdown start value; the counter reaches 1 in the cycle the memory
  // presents the read data.
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  state_e        state_q,     state_d;
  logic          own_data_q,  own_data_d;   // 1 = data port owns the transaction
  logic [2:0]    lat_q,       lat_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q,    if_ack_d;
  logic          d_ack_q,     d_ack_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
  logic [7:0]    cnt_q,       cnt_d;
  logic          busy_q,      busy_d;

  // Request qualification: data is always eligible, fetch only while running.
  logic elig_data;
  logic elig_fetch;
  logic grant_data;

  assign elig_data  = d_req;
  assign elig_fetch = if_req & ~hlt;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which port won the most recent grant (1 = data). Reset value
  // "fetch" makes the first conflict after reset go to data.
  logic last_data_q, last_data_d;

  assign grant_data = (elig_data & elig_fetch) ? ~last_data_q : elig_data;
`else
  // Fixed priority: data wins whenever it is eligible.
  assign grant_data = elig_data;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_d     = state_q;
    own_data_d  = own_data_q;
    lat_d       = lat_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (elig_data && elig_fetch && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (elig_data || elig_fetch) begin
          // Latch the winner's command so the memory port is stable from
          // ISSUE through ACK, independent of what the requesters do next.
          state_d     = S_ISSUE;
          own_data_d  = grant_data;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_data & d_we;
          mem_addr_d  = grant_data ? d_addr  : if_addr;
          mem_wdata_d = grant_data ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_d = grant_data;
`endif
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        lat_d   = LAT_LOAD;
      end

      S_WAIT: begin
        if (lat_q == 3'd1) begin
          state_d = S_ACK;
          if (own_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_we_q ? '0 : mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      S_ACK: begin
        // A request still high here is ignored; it is re-sampled in IDLE.
        state_d  = S_IDLE;
        mem_we_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      own_data_q  <= 1'b0;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_data_q  <= own_data_d;
      lat_q       <= lat_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`endif

  // All outputs come straight from registers.
  assign if_ack       = if_ack_q;
  assign if_rdata     = if_rdata_q;
  assign d_ack        = d_ack_q;
  assign d_rdata      = d_rdata_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A transaction-level reference model
// tracks the current grant (cycle, owner, command) and derives every expected
// output from the timeline: mem_en one cycle after the grant, ack MEM_LAT+2
// cycles after it, and IDLE again one cycle after the ack. A shadow copy of the
// memory supplies the expected read data. Directed sequences are followed by
// randomized requesters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hlt = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_ack, d_ack, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hlt          (hlt),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ack       (if_ack),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .conflict_cnt (conflict_cnt)
  );

  // Memory: write on the mem_en edge; read data appears LAT cycles after that
  // edge and is valid for that cycle only (zero otherwise).
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem_en ? mem[mem_addr] : 8'h00;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [DW-1:0] shadow [256];
  bit            have_txn;
  int            g;                 // cycle in which the grant was sampled
  bit            own_d;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata;
  bit            t_we;
  logic [DW-1:0] m_if_rdata, m_d_rdata;
  int            m_cnt;
  bit            m_last_d;
  bit            exp_if_ack, exp_d_ack;

  task automatic model_reset();
    have_txn   = 1'b0;
    g          = 0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_cnt      = 0;
    m_last_d   = 1'b0;
    exp_if_ack = 1'b0;
    exp_d_ack  = 1'b0;
  endtask

  function automatic bit m_idle();
    return !have_txn || (cyc >= g + LAT + 3);
  endfunction

  // Consume the inputs presented in the current cycle.
  task automatic model_sample();
    bit ed, ef, win_d;
    if (m_idle()) begin
      ed = d_req;
      ef = if_req && !hlt;
      if (ed && ef && m_cnt < 255) m_cnt++;
      if (ed || ef) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = (ed && ef) ? !m_last_d : ed;
`else
        win_d = ed;
`endif
        m_last_d = win_d;
        have_txn = 1'b1;
        g        = cyc;
        own_d    = win_d;
        if (win_d) begin
          t_addr  = d_addr;
          t_we    = d_we;
          t_wdata = d_wdata;
          t_rdata = d_we ? 8'h00 : shadow[d_addr];
          if (d_we) shadow[d_addr] = d_wdata;
        end else begin
          t_addr  = if_addr;
          t_we    = 1'b0;
          t_wdata = '0;
          t_rdata = shadow[if_addr];
        end
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_outputs();
    bit in_txn, ack_now;
    in_txn     = have_txn && cyc >= g + 1 && cyc <= g + LAT + 2;
    ack_now    = have_txn && cyc == g + LAT + 2;
    exp_if_ack = ack_now && !own_d;
    exp_d_ack  = ack_now && own_d;
    if (ack_now) begin
      if (own_d) m_d_rdata = t_rdata;
      else       m_if_rdata = t_rdata;
    end
    check("busy",         32'(busy),         32'(in_txn));
    check("mem_en",       32'(mem_en),       32'(have_txn && cyc == g + 1));
    check("if_ack",       32'(if_ack),       32'(exp_if_ack));
    check("d_ack",        32'(d_ack),        32'(exp_d_ack));
    check("if_rdata",     32'(if_rdata),     32'(m_if_rdata));
    check("d_rdata",      32'(d_rdata),      32'(m_d_rdata));
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    if (in_txn) begin
      check("mem_addr", 32'(mem_addr), 32'(t_addr));
      check("mem_we",   32'(mem_we),   32'(t_we));
      if (t_we) check("mem_wdata", 32'(mem_wdata), 32'(t_wdata));
    end
  endtask

  // One clock: model sees this cycle's inputs, then outputs of the next cycle
  // are checked on the falling edge.
  task automatic tick();
    model_sample();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    hlt    = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_mem_we",    32'(mem_we),    32'h0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
    rst_n = 1'b1;
  endtask

  // Run one transaction from an IDLE cycle; returns cycles to ack, the
  // returned data and mem_we as seen in the ISSUE cycle.
  task automatic xact(input bit is_d, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int hlt_at,
                      output int lat, output logic [DW-1:0] rd, output logic iss_we);
    bit done;
    done = 1'b0; lat = 0; rd = '0; iss_we = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 1; n <= LAT + 20 && !done; n++) begin
      tick();
      if (n == hlt_at) hlt = 1'b1;
      if (n == 1) iss_we = mem_we;
      if (is_d ? d_ack : if_ack) begin
        done = 1'b1;
        lat  = n;
        rd   = is_d ? d_rdata : if_rdata;
      end
    end
    if (is_d) d_req = 1'b0;
    else      if_req = 1'b0;
    check("xact_done", 32'(done), 32'h1);
    tick();  // leave ACK so the next call starts in IDLE
  endtask

  // Hold both requests until n_acks transactions complete.
  task automatic run_conflicts(input int n_acks, output int acks, output logic [3:0] seq,
                               output int n_fetch);
    acks = 0; seq = '0; n_fetch = 0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int n = 0; n < n_acks * (LAT + 3) + 50 && acks < n_acks; n++) begin
      tick();
      if (d_ack || if_ack) begin
        if (acks < 4) seq[acks] = d_ack;
        n_fetch += int'(if_ack);
        acks++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int            lat, acks, nf, saved;
    logic [DW-1:0] rd;
    logic          iw;
    logic [3:0]    seq;
    bit            seen;
    logic [DW-1:0] v;

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      if (i == 'h10) v = 8'hA5;
      mem[i]    <= v;
      shadow[i]  = v;
    end
    model_reset();

    // Reset state
    #12;
    check_outputs();
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    check_outputs();

    // Single fetch of 0xA5 from 0x10
    xact(1'b0, 1'b0, 8'h10, 8'h00, -1, lat, rd, iw);
    check("fetch_lat",   32'(lat), 32'(LAT + 2));
    check("fetch_rdata", 32'(rd),  32'h A5);
    check("fetch_idle",  32'(busy), 32'h0);

    // Store then load
    xact(1'b1, 1'b1, 8'h20, 8'h5A, -1, lat, rd, iw);
    check("store_issue_we", 32'(iw), 32'h1);
    check("store_rdata",    32'(rd), 32'h0);
    xact(1'b1, 1'b0, 8'h20, 8'h00, -1, lat, rd, iw);
    check("load_issue_we", 32'(iw), 32'h0);
    check("load_rdata",    32'(rd), 32'h5A);
    check("load_lat",      32'(lat), 32'(LAT + 2));

    // hlt blocks fetch grants but not data
    hlt = 1'b1; if_req = 1'b1; if_addr = 8'h50;
    saved = m_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("hlt_busy", 32'(busy), 32'h0);
    xact(1'b1, 1'b0, 8'h51, 8'h00, -1, lat, rd, iw);
    check("hlt_data_served", 32'(lat), 32'(LAT + 2));
    check("hlt_cnt_same", 32'(conflict_cnt), 32'(saved));
    if_req = 1'b0; hlt = 1'b0;
    tick();

    // hlt raised during WAIT of a fetch: the fetch still completes
    xact(1'b0, 1'b0, 8'h60, 8'h00, 2, lat, rd, iw);
    check("hlt_mid_lat",   32'(lat), 32'(LAT + 2));
    check("hlt_mid_rdata", 32'(rd),  32'(shadow[8'h60]));
    hlt = 1'b0;
    tick();

    // Reset during WAIT
    if_req = 1'b1; if_addr = 8'h30;
    tick(); tick();
    check("wait_busy", 32'(busy), 32'h1);
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= (if_ack | d_ack);
    end
    check("no_ack_after_rst", 32'(seen), 32'h0);
    xact(1'b0, 1'b0, 8'h30, 8'h00, -1, lat, rd, iw);
    check("post_rst_lat",   32'(lat), 32'(LAT + 2));
    check("post_rst_rdata", 32'(rd),  32'(shadow[8'h30]));

    // Four back-to-back conflicts
    if_addr = 8'h40; d_addr = 8'h41;
    run_conflicts(4, acks, seq, nf);
    check("conf4_acks", 32'(acks), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
    check("conf4_seq",   32'(seq), 32'b0101);
    check("conf4_fetch", 32'(nf),  32'd2);
`else
    check("conf4_seq",   32'(seq), 32'b1111);
    check("conf4_fetch", 32'(nf),  32'd0);
`endif
    check("conf4_cnt", 32'(conflict_cnt), 32'd4);

    // Saturation after 300 conflicting IDLE cycles
    run_conflicts(300, acks, seq, nf);
    check("sat_acks", 32'(acks), 32'd300);
    check("sat_cnt",  32'(conflict_cnt), 32'd255);

    // Randomized requesters
    for (int n = 0; n < 2000; n++) begin
      if (if_req && exp_if_ack) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = 8'($urandom_range(0, 31));
      end
      if (d_req && exp_d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 8'($urandom_range(0, 31));
        d_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0) hlt = ~hlt;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
